mul_div_sequencer: RTL and testbench
====================================

Name: mul_div_sequencer

Overview:
- Iterative signed multiply/divide unit for the CPU datapath; writes the HI/LO result registers.
- Radix-2 Booth multiply and signed restoring divide share one WIDTH-bit add/subtract datapath, one step per clock.
- The controller latches operands, runs WIDTH iterations, applies sign fix-up, writes HI/LO, then pulses done.
- Issued by the control unit on mul/div instructions; it holds the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, iteration count = WIDTH.

Ports:
- clock  input  1  system clock, rising-edge.
- clear  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- op  input  1  0 = signed multiply, 1 = signed divide.
- a  input  WIDTH  multiply: multiplier (Q). Divide: dividend.
- b  input  WIDTH  multiply: multiplicand (M). Divide: divisor.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; HI/LO and div_by_zero are valid from this cycle onward.
- hi  output  WIDTH  multiply: product[2W-1:W]. Divide: remainder.
- lo  output  WIDTH  multiply: product[W-1:0]. Divide: quotient.
- div_by_zero  output  1  set with done when op=1 and b=0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (clear=0, at any time, including mid-operation):
  - state=IDLE; busy, done, div_by_zero = 0; hi, lo = 0; iteration counter = 0.
  - The in-flight operation is discarded.
- States: IDLE, RUN, FIX. busy = (state != IDLE). All outputs are registered.
- IDLE:
  - On an edge E0 with start=1, latch a, b and op; counter = 0; go to RUN.
  - done drops to 0 on the first edge after it was set.
  - div_by_zero is cleared at E0.
- RUN: one iteration on each of edges E1..EWIDTH; after the last iteration go to FIX.
- FIX (edge EWIDTH+1):
  - Write hi and lo, set done=1, go to IDLE.
  - Latency: done is high during the cycle after edge E(WIDTH+1); that is E33 for the default width.
- Multiply iteration:
  - Registers: A (WIDTH bits, init 0), Q = a, q_1 = 0, M = b.
  - {Q[0], q_1} = 10: A = A - M. 01: A = A + M. 00 or 11: no change.
  - Then arithmetic right shift of {A, Q, q_1} by one, sign-replicating A's MSB.
  - In FIX: hi = A, lo = Q. The full 2W-bit two's-complement product is exact.
  - Subtraction is A + ~M + 1. The Booth form that omits the +1 is not acceptable.
- Divide:
  - At E0, latch the magnitudes of a and b and the signs sa, sb.
  - Restoring division on the magnitudes:
    - Shift {R, Q} left by one.
    - Trial-subtract |b| from R, using a WIDTH+1-bit subtract.
    - If the result is non-negative, keep it and set Q[0] = 1.
  - FIX:
    - Quotient is negated if sa ^ sb, so it truncates toward zero.
    - Remainder is negated if sa, so its sign follows the dividend.
  - Special case -2^(W-1) / -1: lo = 0x80000000, hi = 0 (wraps, no flag).
- Divide by zero (op=1, b=0):
  - The same full latency is used.
  - FIX writes hi = a, lo = all ones, div_by_zero = 1.
- Handshake rules:
  - start while busy=1 is ignored; operands are not re-latched.
  - start during the done cycle is accepted, because state is already IDLE.
  - Back-to-back operations therefore run with zero idle cycles.
- Holding:
  - hi and lo hold their values until the next FIX.
  - A new start does not clear hi or lo.
  - op, a and b may change freely after E0.

Test Plan:
- Multiply: op=0, a=3, b=-5 → busy for 33 cycles; done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Multiply corner: a=b=0x80000000 → hi=0x40000000, lo=0x00000000. Also a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0, lo=1.
- Divide signs:
  - a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=7, b=-2 → lo=0xFFFFFFFD, hi=1.
  - a=0x80000000, b=-1 → lo=0x80000000, hi=0.
- Divide by zero: a=0x12345678, b=0 → done after 33 cycles; hi=0x12345678, lo=0xFFFFFFFF, div_by_zero=1. The next start clears div_by_zero at E0.
- Handshake:
  - Pulse start with a=6, b=7 during RUN of a 2×3 multiply → result lo=6, and the stray start is ignored.
  - Then assert start in the done cycle → second result appears exactly 33 cycles later.
- Reset: drop clear at iteration 10 of a multiply → busy, done, hi and lo read 0 immediately, with no clock edge needed. Release clear, then run 9×9 → lo=81, hi=0.

Source files
------------

// File: rtl/mul_div_sequencer.sv
// Iterative signed multiply (radix-2 Booth) / signed restoring divide on one shared add/sub datapath.
// Latency WIDTH+1 edges after the start edge; start is ignored while busy, and accepted again in the done cycle.
module mul_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] mreg;
  logic             q_1;
  logic             op_r;
  logic             sa;
  logic             sb;
  logic             dz;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;

  // One extra bit keeps the Booth accumulator exact for M = -2^(W-1)
  // and gives the divide trial-subtract its borrow bit.
  always_comb begin
    add_x   = {acc[WIDTH-1], acc};
    add_y   = '0;
    add_cin = 1'b0;
    if (op_r) begin
      add_x   = {acc, qreg[WIDTH-1]};
      add_y   = ~{1'b0, mreg};
      add_cin = 1'b1;
    end else if (qreg[0] && !q_1) begin
      add_y   = ~{mreg[WIDTH-1], mreg};
      add_cin = 1'b1;
    end else if (!qreg[0] && q_1) begin
      add_y   = {mreg[WIDTH-1], mreg};
    end
  end

  assign sum  = add_x + add_y + {{WIDTH{1'b0}}, add_cin};
  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      acc         <= '0;
      qreg        <= '0;
      mreg        <= '0;
      q_1         <= 1'b0;
      op_r        <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      dz          <= 1'b0;
      cnt         <= '0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r        <= op;
            sa          <= a[WIDTH-1];
            sb          <= b[WIDTH-1];
            dz          <= op && (b == '0);
            acc         <= '0;
            q_1         <= 1'b0;
            qreg        <= (op && a[WIDTH-1]) ? -a : a;
            mreg        <= (op && b[WIDTH-1]) ? -b : b;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (op_r) begin
            if (!sum[WIDTH]) begin
              acc  <= sum[WIDTH-1:0];
              qreg <= {qreg[WIDTH-2:0], 1'b1};
            end else begin
              acc  <= {acc[WIDTH-2:0], qreg[WIDTH-1]};
              qreg <= {qreg[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc  <= sum[WIDTH:1];
            qreg <= {sum[0], qreg[WIDTH-1:1]};
            q_1  <= qreg[0];
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          // With a zero divisor every trial succeeds, so the remainder
          // rebuilds |a| and the sign fix-up returns the dividend itself.
          hi          <= (op_r && sa) ? -acc : acc;
          lo          <= !op_r ? qreg : (dz ? '1 : ((sa ^ sb) ? -qreg : qreg));
          div_by_zero <= dz;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer: signed mul/div results, latency, handshake and async reset.
module tb_mul_div_sequencer;

  logic        clock;
  logic        clear;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive a request at a negedge; returns just after its E0 edge.
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = $urandom_range(0, 1);
  endtask

  // Counts edges after the current point until done is seen; bounded.
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock);
      #1;
      if (busy) bc++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_case(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    int lat, bc;
    issue(o, x, y);
    chk({tag, "_busy_e0"}, busy, 1);
    chk({tag, "_done_e0"}, done, 0);
    wait_done(lat, bc);
    chk({tag, "_lat"}, lat, 33);
    chk({tag, "_busycyc"}, bc + 1, 33);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_dz"}, div_by_zero, edz);
  endtask

  initial begin
    int lat, bc;
    clear = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dz", div_by_zero, 0);
    @(negedge clock);
    clear = 1'b1;

    run_case("mul_3x-5", 1'b0, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    @(posedge clock); #1;
    chk("done_pulse", done, 0);
    run_case("mul_min2", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_case("mul_m1m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
    run_case("div_-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_case("div_7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);
    run_case("div_min_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_case("div_by_0", 1'b1, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);

    // Stray start during RUN must be ignored; results of the previous op must hold.
    issue(1'b0, 32'd2, 32'd3);
    chk("dz_clr_e0", div_by_zero, 0);
    chk("hold_lo", lo, 32'hFFFF_FFFF);
    repeat (5) @(negedge clock);
    start = 1'b1; op = 1'b0; a = 32'd6; b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(lat, bc);
    chk("stray_lat", lat, 28);
    chk("stray_lo", lo, 32'd6);
    chk("stray_hi", hi, 32'd0);

    // Start in the done cycle: accepted, second result 33 edges later.
    @(negedge clock);
    chk("b2b_done", done, 1);
    start = 1'b1; op = 1'b0; a = 32'd4; b = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_drop", done, 0);
    wait_done(lat, bc);
    chk("b2b_lat", lat, 33);
    chk("b2b_lo", lo, 32'd20);

    // Asynchronous reset mid-operation.
    issue(1'b0, 32'h0000_1234, 32'h0000_5678);
    repeat (10) @(posedge clock);
    #2;
    clear = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    @(negedge clock);
    clear = 1'b1;
    run_case("mul_9x9", 1'b0, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
